spikecnt_multi: RTL and testbench
=================================

Name: spikecnt_multi

Overview:
- Parametrised, multi-channel successor to the single-channel spike counter used on the board top level.
- Counts rising edges on NCH spike lines in the fast neuron_clk domain and snapshots every channel on each rising edge of slow_clk (sim_clk).
- Adds saturation, sticky overflow flags, windowed/cumulative modes and an addressed readback port.
- Snapshots feed okWireOut endpoints, and MN_spk / spike_in1 / future cross-board spikes share one instance.

Parameters:
- NCH, 2, number of spike channels (>=1).
- CNT_W, 32, counter and snapshot width per channel.
- SYNC_STAGES, 2, synchroniser depth on spike_in and slow_clk (>=2).
- SEL_W, localparam = max(1, clog2(NCH)), readback select width.

Ports:
- clk  in  1  fast counting clock (neuron_clk).
- reset_global  in  1  reset, asynchronous, active-high.
- soft_clear  in  1  synchronous clear (driven by reset_sim).
- slow_clk  in  1  window clock (sim_clk); treated as asynchronous data.
- mode  in  1  0 = windowed (clear each window), 1 = cumulative.
- spike_in  in  NCH  spike levels; may be asynchronous (cross-board).
- rd_sel  in  SEL_W  readback channel index.
- rd_data  out  CNT_W  registered snapshot of channel rd_sel.
- rd_ovf  out  1  registered overflow flag of channel rd_sel.
- snap_all  out  NCH*CNT_W  all snapshots, flattened; channel k at [k*CNT_W +: CNT_W].
- win_tick  out  1  one-clk pulse when new snapshots are visible.

Behaviour:
- Reset state (reset_global): all synchroniser flops, edge-history flops, counts, snapshots, overflow flags, rd_data, rd_ovf and win_tick are 0.
- Input conditioning:
  - Each spike_in bit and slow_clk passes through SYNC_STAGES flops, then a previous-value flop.
  - A rising edge is synced=1 and prev=0.
  - A level held high for many cycles counts once.
  - Pulses shorter than one clk period may be missed; this is accepted.
- Alignment: the spike and slow_clk paths have identical depth. An input edge sampled at clk edge n acts at clk edge n+SYNC_STAGES+1.
- Boundary cycle (slow_clk rising edge detected):
  - snap[k] <= count[k] for every channel. This is the value before this cycle's increment.
  - Windowed mode: count[k] <= spike_edge[k] ? 1 : 0, and ovf[k] <= 0.
  - Cumulative mode: count[k] increments as normal, and ovf[k] is unchanged.
  - A spike edge coinciding with the boundary always belongs to the new window.
  - win_tick = 1 in the cycle after the boundary edge, i.e. the same edge at which snap becomes visible. It is 0 otherwise.
- Mode: sampled only in the boundary cycle. A mode change mid-window affects only how that boundary clears the counts.
- Counting:
  - count[k] <= count[k]+1 on a spike edge.
  - At count = 2^CNT_W-1 a further edge holds the count and sets ovf[k].
  - Counts never wrap.
- Readback:
  - rd_data <= snap[rd_sel] and rd_ovf <= ovf_snap[rd_sel], with 1 clk latency.
  - ovf_snap[k] is captured with snap[k].
  - rd_sel >= NCH gives rd_data = 0 and rd_ovf = 0.
- soft_clear:
  - Highest priority over boundary and spike in the same cycle.
  - Zeroes counts, snapshots, ovf, ovf_snap and win_tick.
  - Synchroniser and edge-history flops keep running, so no false edge appears after clear.
  - Edges arriving while soft_clear is high are discarded.
- Reset release with spike_in held high: the edge propagates through the synchroniser and is counted exactly once.
- Reset mid-window: all state returns to 0 immediately (asynchronous); no partial snapshot is kept.

Decomposition:
- Shared package nerf_pkg:
  - MODE_WINDOW = 1'b0, MODE_CUMUL = 1'b1.
  - Default CNT_W = 32 and SYNC_STAGES = 2 constants for board tops.
- Sub-module spike_edge_sync:
  - Parameter SYNC_STAGES; ports clk, reset_global, d, edge_out.
  - Instantiated NCH+1 times: one per spike channel plus one for slow_clk.
- Counter, saturation, snapshot and readback logic lives in spikecnt_multi (generate loop over NCH).

Test Plan (NCH=2, SYNC_STAGES=2 unless stated):
1. Windowed count, CNT_W=32: 5 pulses on ch0 and 3 on ch1 (each 4 clk wide), then slow_clk rises → win_tick pulses once; snap_all = {3,5}; rd_sel=1 gives rd_data=3 one clk later; counts restart at 0.
2. Coincident edge: ch0 spike edge and slow_clk edge sampled on the same clk → snap[0] excludes it; the next window's snapshot for ch0 = 1 with no further spikes.
3. Saturation, CNT_W=8: 300 edges on ch0 within one window → snap[0] = 255 and rd_ovf = 1; the next window with 2 edges gives 2 and ovf = 0.
4. Cumulative, mode=1: 4 edges in window 1 and 6 in window 2 → snapshots 4 then 10; switching to mode=0 then gives 10+n at the next boundary and a clear after it.
5. soft_clear asserted for one clk, coincident with a ch1 edge and a boundary → counts, snapshots and ovf are 0; win_tick is not asserted; the following window counts from 0.
6. Reset: spike_in=2'b11 held through reset_global release → exactly one count per channel at the next snapshot; asserting reset_global mid-window zeroes all outputs asynchronously.

Source files
------------

// File: rtl/nerf_pkg.sv
// Shared constants for the NERF board spike-counting blocks.
package nerf_pkg;

    localparam logic MODE_WINDOW = 1'b0;
    localparam logic MODE_CUMUL  = 1'b1;

    localparam int NERF_CNT_W       = 32;
    localparam int NERF_SYNC_STAGES = 2;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_edge_sync.sv
// Synchronises one asynchronous level into clk and emits a registered one-cycle
// pulse per rising edge.
module spike_edge_sync
    import nerf_pkg::*;
#(
    parameter int SYNC_STAGES = NERF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_global,
    input  logic d,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;

    // Edge flop adds one stage so every instance has the same total latency.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign edge_out = r_edge;

endmodule

// File: rtl/spikecnt_multi.sv
// Multi-channel saturating spike counter with per-window snapshots, sticky
// overflow flags and an addressed readback port.
module spikecnt_multi
    import nerf_pkg::*;
#(
    parameter  int NCH         = 2,
    parameter  int CNT_W       = NERF_CNT_W,
    parameter  int SYNC_STAGES = NERF_SYNC_STAGES,
    localparam int SEL_W       = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 reset_global,
    input  logic                 soft_clear,
    input  logic                 slow_clk,
    input  logic                 mode,
    input  logic [NCH-1:0]       spike_in,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic [CNT_W-1:0]     rd_data,
    output logic                 rd_ovf,
    output logic [NCH*CNT_W-1:0] snap_all,
    output logic                 win_tick
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [NCH-1:0]   w_spk_edge;
    logic             w_boundary;
    logic [CNT_W-1:0] w_snap [NCH];
    logic [NCH-1:0]   w_ovf_snap;
    logic [CNT_W-1:0] w_rd_data;
    logic             w_rd_ovf;
    logic             r_win_tick;
    logic [CNT_W-1:0] r_rd_data;
    logic             r_rd_ovf;

    // slow_clk goes through the same conditioning so boundaries align with spikes.
    spike_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_slow_sync (
        .clk          (clk),
        .reset_global (reset_global),
        .d            (slow_clk),
        .edge_out     (w_boundary)
    );

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [CNT_W-1:0] r_count;
        logic [CNT_W-1:0] r_snap;
        logic             r_ovf;
        logic             r_ovf_snap;

        spike_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_spk_sync (
            .clk          (clk),
            .reset_global (reset_global),
            .d            (spike_in[k]),
            .edge_out     (w_spk_edge[k])
        );

        // A spike coinciding with a windowed boundary seeds the new window.
        always_ff @(posedge clk or posedge reset_global) begin
            if (reset_global) begin
                r_count    <= '0;
                r_snap     <= '0;
                r_ovf      <= 1'b0;
                r_ovf_snap <= 1'b0;
            end else if (soft_clear) begin
                r_count    <= '0;
                r_snap     <= '0;
                r_ovf      <= 1'b0;
                r_ovf_snap <= 1'b0;
            end else begin
                if (w_boundary) begin
                    r_snap     <= r_count;
                    r_ovf_snap <= r_ovf;
                end
                if (w_boundary && (mode == MODE_WINDOW)) begin
                    r_count <= w_spk_edge[k] ? CNT_W'(1) : '0;
                    r_ovf   <= 1'b0;
                end else if (w_spk_edge[k]) begin
                    r_count <= sat_inc(r_count);
                    if (r_count == CNT_MAX) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end

        assign w_snap[k]                   = r_snap;
        assign w_ovf_snap[k]               = r_ovf_snap;
        assign snap_all[k*CNT_W +: CNT_W]  = r_snap;
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        w_rd_data = '0;
        w_rd_ovf  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (rd_sel == SEL_W'(k)) begin
                w_rd_data = w_snap[k];
                w_rd_ovf  = w_ovf_snap[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_win_tick <= 1'b0;
            r_rd_data  <= '0;
            r_rd_ovf   <= 1'b0;
        end else begin
            r_win_tick <= w_boundary & ~soft_clear;
            r_rd_data  <= w_rd_data;
            r_rd_ovf   <= w_rd_ovf;
        end
    end

    assign win_tick = r_win_tick;
    assign rd_data  = r_rd_data;
    assign rd_ovf   = r_rd_ovf;

endmodule

// File: tb/tb_spikecnt_multi.sv
// Scoreboard bench for spikecnt_multi: a 32-bit and an 8-bit instance share stimulus.
module tb_spikecnt_multi;

    logic        clk = 1'b0;
    logic        reset_global;
    logic        soft_clear;
    logic        slow_clk;
    logic        mode;
    logic [1:0]  spike_in;
    logic [0:0]  rd_sel;

    logic [31:0] rd_data;
    logic        rd_ovf;
    logic [63:0] snap_all;
    logic        win_tick;

    logic [7:0]  s_rd_data;
    logic        s_rd_ovf;
    logic [15:0] s_snap_all;
    logic        s_win_tick;

    always #5 clk = ~clk;

    spikecnt_multi #(.NCH(2), .CNT_W(32), .SYNC_STAGES(2)) u_dut (
        .clk          (clk),
        .reset_global (reset_global),
        .soft_clear   (soft_clear),
        .slow_clk     (slow_clk),
        .mode         (mode),
        .spike_in     (spike_in),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
        .rd_ovf       (rd_ovf),
        .snap_all     (snap_all),
        .win_tick     (win_tick)
    );

    spikecnt_multi #(.NCH(2), .CNT_W(8), .SYNC_STAGES(2)) u_sat (
        .clk          (clk),
        .reset_global (reset_global),
        .soft_clear   (soft_clear),
        .slow_clk     (slow_clk),
        .mode         (mode),
        .spike_in     (spike_in),
        .rd_sel       (rd_sel),
        .rd_data      (s_rd_data),
        .rd_ovf       (s_rd_ovf),
        .snap_all     (s_snap_all),
        .win_tick     (s_win_tick)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] a0, a1;
        logic [7:0]  b0, b1;
        logic        v0, v1;
    } exp_t;

    exp_t        q[$];
    int unsigned m32 [2];
    int          m8  [2];
    bit          mo  [2];

    task automatic model_zero();
        for (int k = 0; k < 2; k++) begin
            m32[k] = 0;
            m8[k]  = 0;
            mo[k]  = 1'b0;
        end
    endtask

    task automatic add(input int ch);
        m32[ch]++;
        if (m8[ch] == 255) mo[ch] = 1'b1;
        else               m8[ch]++;
    endtask

    task automatic pulses(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            spike_in[ch] = 1'b1;
            add(ch);
            repeat (4) @(negedge clk);
            spike_in[ch] = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic window_close(input logic [1:0] coin);
        exp_t e;
        @(negedge clk);
        e.a0 = m32[0];
        e.a1 = m32[1];
        e.b0 = 8'(m8[0]);
        e.b1 = 8'(m8[1]);
        e.v0 = mo[0];
        e.v1 = mo[1];
        q.push_back(e);
        if (mode == 1'b0) model_zero();
        for (int k = 0; k < 2; k++) if (coin[k]) add(k);
        slow_clk = 1'b1;
        spike_in = spike_in | coin;
        repeat (6) @(negedge clk);
        slow_clk = 1'b0;
        spike_in = spike_in & ~coin;
        repeat (10) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (win_tick) begin
                chk("tick_has_expect", 64'(q.size() != 0), 64'd1);
                chk("sat_tick_aligned", 64'(s_win_tick), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("snap_all", snap_all, {e.a1, e.a0});
                    chk("sat_snap_all", 64'(s_snap_all), {48'd0, e.b1, e.b0});
                    @(negedge clk);
                    chk("tick_width", 64'(win_tick), 64'd0);
                    chk("rd_data", 64'(rd_data), 64'(rd_sel[0] ? e.a1 : e.a0));
                    chk("sat_rd_data", 64'(s_rd_data), 64'(rd_sel[0] ? e.b1 : e.b0));
                    chk("sat_rd_ovf", 64'(s_rd_ovf), 64'(rd_sel[0] ? e.v1 : e.v0));
                    chk("rd_ovf", 64'(rd_ovf), 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        reset_global = 1'b1;
        soft_clear   = 1'b0;
        slow_clk     = 1'b0;
        mode         = 1'b0;
        spike_in     = 2'b11;
        rd_sel       = 1'b0;
        model_zero();
        repeat (3) @(negedge clk);
        chk("rst_snap_all", snap_all, 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_rd_ovf", 64'(rd_ovf), 64'd0);
        chk("rst_win_tick", 64'(win_tick), 64'd0);
        chk("rst_sat_snap_all", 64'(s_snap_all), 64'd0);

        // spike_in held high across reset release counts once per channel
        reset_global = 1'b0;
        add(0);
        add(1);
        repeat (8) @(negedge clk);
        spike_in = 2'b00;
        repeat (4) @(negedge clk);
        window_close(2'b00);

        // windowed counting with readback of channel 1
        rd_sel = 1'b1;
        pulses(0, 5);
        pulses(1, 3);
        window_close(2'b00);
        window_close(2'b00);

        // ch0 edge coincident with boundary belongs to the new window
        window_close(2'b01);
        window_close(2'b00);

        // saturation of the 8-bit instance
        rd_sel = 1'b0;
        pulses(0, 300);
        window_close(2'b00);
        pulses(0, 2);
        window_close(2'b00);

        // cumulative mode, then back to windowed
        mode = 1'b1;
        pulses(0, 4);
        window_close(2'b00);
        pulses(0, 6);
        window_close(2'b00);
        mode = 1'b0;
        pulses(0, 3);
        window_close(2'b00);
        pulses(0, 2);
        pulses(1, 1);
        window_close(2'b00);

        // soft_clear coincident with a ch1 edge and a boundary
        pulses(0, 1);
        @(negedge clk);
        spike_in[1] = 1'b1;
        slow_clk    = 1'b1;
        repeat (3) @(negedge clk);
        soft_clear = 1'b1;
        @(negedge clk);
        soft_clear = 1'b0;
        model_zero();
        chk("sclr_snap_all", snap_all, 64'd0);
        chk("sclr_sat_snap_all", 64'(s_snap_all), 64'd0);
        chk("sclr_win_tick", 64'(win_tick), 64'd0);
        @(negedge clk);
        chk("sclr_rd_data", 64'(rd_data), 64'd0);
        chk("sclr_sat_rd_ovf", 64'(s_rd_ovf), 64'd0);
        repeat (4) @(negedge clk);
        spike_in[1] = 1'b0;
        slow_clk    = 1'b0;
        repeat (8) @(negedge clk);
        pulses(0, 2);
        window_close(2'b00);

        // asynchronous reset in the middle of a window
        pulses(1, 2);
        @(negedge clk);
        #2 reset_global = 1'b1;
        #1;
        chk("arst_snap_all", snap_all, 64'd0);
        chk("arst_sat_snap_all", 64'(s_snap_all), 64'd0);
        chk("arst_rd_data", 64'(rd_data), 64'd0);
        chk("arst_win_tick", 64'(win_tick), 64'd0);
        model_zero();
        @(negedge clk);
        reset_global = 1'b0;
        repeat (4) @(negedge clk);
        pulses(1, 1);
        window_close(2'b00);

        repeat (10) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
